// File: rtl/cache_refill_ctrl_if.sv
// Miss, memory-bus and fill channels of the cache refill controller.
// The master modport is the controller's own view; slave is the cache/memory side.
interface cache_refill_ctrl_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned WORDS   = 4
);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 4;

  logic                  miss_v_i;
  logic                  miss_ready_o;
  logic [ADDR_W-1:0]     miss_addr_i;
  logic                  victim_dirty_i;
  logic [TAG_W-1:0]      victim_tag_i;
  logic [WORDS*32-1:0]   victim_line_i;

  logic                  mem_req_v_o;
  logic                  mem_req_ready_i;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic                  mem_rdata_v_i;
  logic [31:0]           mem_rdata_i;

  logic                  fill_v_o;
  logic [INDEX_W-1:0]    fill_index_o;
  logic [TAG_W-1:0]      fill_tag_o;
  logic [WORDS*32-1:0]   fill_line_o;
  logic                  busy_o;

  modport master (
    input  miss_v_i, miss_addr_i, victim_dirty_i, victim_tag_i, victim_line_i,
    input  mem_req_ready_i, mem_rdata_v_i, mem_rdata_i,
    output miss_ready_o, mem_req_v_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output fill_v_o, fill_index_o, fill_tag_o, fill_line_o, busy_o
  );

  modport slave (
    output miss_v_i, miss_addr_i, victim_dirty_i, victim_tag_i, victim_line_i,
    output mem_req_ready_i, mem_rdata_v_i, mem_rdata_i,
    input  miss_ready_o, mem_req_v_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  fill_v_o, fill_index_o, fill_tag_o, fill_line_o, busy_o
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Memory-side miss handler: writes back a dirty victim word by word, refills the missing line
// one word at a time, then returns the assembled line to the cache as a one-cycle fill strobe.
module cache_refill_ctrl #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INDEX_W = 4,
  parameter int unsigned WORDS   = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  cache_refill_ctrl_if.master bus
);
  localparam int unsigned TAG_W = ADDR_W - INDEX_W - 4;
  localparam int unsigned LineW = WORDS * 32;
  localparam int unsigned KW    = $clog2(WORDS);
  localparam logic [KW-1:0] KLast = KW'(WORDS - 1);

  typedef enum logic [2:0] {StIdle, StWbReq, StRdReq, StRdData, StFill} state_e;

  state_e               state_q;
  logic [KW-1:0]        k_q;
  logic [KW-1:0]        k_inc;
  logic [TAG_W-1:0]     tag_q;
  logic [INDEX_W-1:0]   index_q;
  logic [TAG_W-1:0]     victim_tag_q;
  logic [LineW-1:0]     victim_line_q;
  logic [LineW-1:0]     line_q;

  logic                 miss_ready_q;
  logic                 mem_req_v_q;
  logic                 mem_we_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic [31:0]          mem_wdata_q;
  logic                 fill_v_q;
  logic [INDEX_W-1:0]   fill_index_q;
  logic [TAG_W-1:0]     fill_tag_q;
  logic [LineW-1:0]     fill_line_q;

  // Byte offset within the line is implied by the word counter.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^bus.miss_addr_i[3:0];

  assign k_inc = k_q + KW'(1);

  // Outputs are decoded into registers at each transition, so nothing combinational
  // reaches the pins from the inputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      k_q           <= '0;
      tag_q         <= '0;
      index_q       <= '0;
      victim_tag_q  <= '0;
      victim_line_q <= '0;
      line_q        <= '0;
      miss_ready_q  <= 1'b1;
      mem_req_v_q   <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      fill_v_q      <= 1'b0;
      fill_index_q  <= '0;
      fill_tag_q    <= '0;
      fill_line_q   <= '0;
    end else begin
      fill_v_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.miss_v_i) begin
            tag_q         <= bus.miss_addr_i[ADDR_W-1 -: TAG_W];
            index_q       <= bus.miss_addr_i[4 +: INDEX_W];
            victim_tag_q  <= bus.victim_tag_i;
            victim_line_q <= bus.victim_line_i;
            k_q           <= '0;
            miss_ready_q  <= 1'b0;
            mem_req_v_q   <= 1'b1;
            if (bus.victim_dirty_i) begin
              state_q     <= StWbReq;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= {bus.victim_tag_i, bus.miss_addr_i[4 +: INDEX_W], 4'h0};
              mem_wdata_q <= bus.victim_line_i[31:0];
            end else begin
              state_q     <= StRdReq;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= {bus.miss_addr_i[ADDR_W-1:4], 4'h0};
              mem_wdata_q <= '0;
            end
          end
        end
        StWbReq: begin
          if (bus.mem_req_ready_i) begin
            if (k_q == KLast) begin
              k_q         <= '0;
              state_q     <= StRdReq;
              mem_we_q    <= 1'b0;
              mem_wdata_q <= '0;
              mem_addr_q  <= {tag_q, index_q, 4'h0};
            end else begin
              k_q         <= k_inc;
              mem_addr_q  <= {victim_tag_q, index_q, k_inc, 2'b00};
              mem_wdata_q <= victim_line_q[32*k_inc +: 32];
            end
          end
        end
        StRdReq: begin
          if (bus.mem_req_ready_i) begin
            state_q     <= StRdData;
            mem_req_v_q <= 1'b0;
          end
        end
        StRdData: begin
          if (bus.mem_rdata_v_i) begin
            line_q[32*k_q +: 32] <= bus.mem_rdata_i;
            if (k_q == KLast) begin
              state_q      <= StFill;
              fill_v_q     <= 1'b1;
              fill_index_q <= index_q;
              fill_tag_q   <= tag_q;
              fill_line_q  <= {bus.mem_rdata_i, line_q[LineW-33:0]};
            end else begin
              k_q         <= k_inc;
              state_q     <= StRdReq;
              mem_req_v_q <= 1'b1;
              mem_addr_q  <= {tag_q, index_q, k_inc, 2'b00};
            end
          end
        end
        StFill: begin
          // miss_ready stays low through the fill cycle, so no accept can overlap it.
          state_q      <= StIdle;
          miss_ready_q <= 1'b1;
          k_q          <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.miss_ready_o = miss_ready_q;
  assign bus.busy_o       = ~miss_ready_q;
  assign bus.mem_req_v_o  = mem_req_v_q;
  assign bus.mem_we_o     = mem_we_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_wdata_o  = mem_wdata_q;
  assign bus.fill_v_o     = fill_v_q;
  assign bus.fill_index_o = fill_index_q;
  assign bus.fill_tag_o   = fill_tag_q;
  assign bus.fill_line_o  = fill_line_q;

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Randomized bench for cache_refill_ctrl: a memory model answers requests while a
// transaction-level reference predicts every request, the filled line and the latency.
module tb_cache_refill_ctrl;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cache_refill_ctrl_if bus ();

  cache_refill_ctrl dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory image; untouched addresses read back a fixed hash of the address.
  bit [31:0] mem_aa [bit [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_aa.exists(a)) return mem_aa[a];
    return {a[15:0], a[31:16]} ^ 32'hC0DE_5A5A;
  endfunction

  function automatic logic [127:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Expected request stream and fill for the current transaction.
  bit           exp_we    [$];
  logic [31:0]  exp_addr  [$];
  logic [31:0]  exp_wdata [$];
  logic [127:0] exp_line;
  logic [23:0]  exp_tag;
  logic [3:0]   exp_index;
  int           n_xfer     = 0;
  bit           txn_active = 1'b0;

  // Memory-side knobs.
  int          rdy_mode  = 0;   // 0: always ready, 1: random, 2: three stall cycles per request
  int          rd_lat    = 0;   // extra cycles before read data returns
  bit          spur_en   = 1'b0;
  bit          pend_v    = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt  = 0;
  int          stall_cnt = 0;

  int           fill_cnt = 0;
  logic [127:0] last_line;
  logic [23:0]  last_tag;
  logic [3:0]   last_index;

  initial begin : fill_mon
    forever begin
      @(negedge clk);
      if (bus.fill_v_o) fill_cnt++;
    end
  end

  initial begin : mem_side
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rdata_v_i   = 1'b0;
    bus.mem_rdata_i     = '0;
    forever begin
      @(negedge clk);
      if (!reset && bus.mem_req_v_o) begin
        if (txn_active) begin
          if (n_xfer < exp_addr.size()) begin
            check_val("req_we", bus.mem_we_o, exp_we[n_xfer]);
            check_val("req_addr", bus.mem_addr_o, exp_addr[n_xfer]);
            check_val("req_wdata", bus.mem_wdata_o, exp_wdata[n_xfer]);
          end else begin
            check_val("req_extra", bus.mem_req_v_o, 1'b0);
          end
        end
        if (bus.mem_req_ready_i) begin
          n_xfer++;
          stall_cnt = 0;
          if (bus.mem_we_o) begin
            mem_aa[bus.mem_addr_o] = bus.mem_wdata_o;
          end else begin
            pend_v    = 1'b1;
            pend_addr = bus.mem_addr_o;
            pend_cnt  = rd_lat;
          end
        end
      end
      @(posedge clk);
      #1;
      bus.mem_rdata_v_i = 1'b0;
      bus.mem_rdata_i   = '0;
      if (pend_v) begin
        if (pend_cnt == 0) begin
          bus.mem_rdata_v_i = 1'b1;
          bus.mem_rdata_i   = mem_rd(pend_addr);
          pend_v            = 1'b0;
        end else begin
          pend_cnt--;
        end
      end else if (spur_en && $urandom_range(0, 2) == 0) begin
        bus.mem_rdata_v_i = 1'b1;
        bus.mem_rdata_i   = 32'h0000_DEAD;
      end
      case (rdy_mode)
        1: bus.mem_req_ready_i = ($urandom_range(0, 3) != 0);
        2: begin
          if (bus.mem_req_v_o && stall_cnt < 3) begin
            bus.mem_req_ready_i = 1'b0;
            stall_cnt++;
          end else begin
            bus.mem_req_ready_i = 1'b1;
          end
        end
        default: bus.mem_req_ready_i = 1'b1;
      endcase
    end
  end

  // Builds the expected transaction and presents the miss for one accept edge.
  task automatic start_miss(input logic [31:0] addr, input bit dirty, input logic [23:0] vtag,
                            input logic [127:0] vline);
    logic [31:0] a;
    @(posedge clk);
    #1;
    exp_we.delete();
    exp_addr.delete();
    exp_wdata.delete();
    if (dirty) begin
      for (int k = 0; k < 4; k++) begin
        exp_we.push_back(1'b1);
        exp_addr.push_back({vtag, addr[7:4], 4'h0} + 32'(4 * k));
        exp_wdata.push_back(vline[32*k +: 32]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      a = {addr[31:4], 4'h0} + 32'(4 * k);
      exp_we.push_back(1'b0);
      exp_addr.push_back(a);
      exp_wdata.push_back(32'h0);
      // A writeback to the very line being refilled lands before the read of that word.
      exp_line[32*k +: 32] = (dirty && vtag == addr[31:8]) ? vline[32*k +: 32] : mem_rd(a);
    end
    exp_tag    = addr[31:8];
    exp_index  = addr[7:4];
    n_xfer     = 0;
    txn_active = 1'b1;
    check_val("idle_ready", bus.miss_ready_o, 1'b1);
    bus.miss_v_i       = 1'b1;
    bus.miss_addr_i    = addr;
    bus.victim_dirty_i = dirty;
    bus.victim_tag_i   = vtag;
    bus.victim_line_i  = vline;
    @(posedge clk);
    #1;
    bus.miss_v_i       = 1'b0;
    bus.miss_addr_i    = $urandom();
    bus.victim_dirty_i = 1'($urandom_range(0, 1));
    bus.victim_tag_i   = 24'($urandom());
    bus.victim_line_i  = rnd_line();
  endtask

  task automatic run_miss(input logic [31:0] addr, input bit dirty, input logic [23:0] vtag,
                          input logic [127:0] vline, input bit poke, input bit chk_lat);
    int cyc;
    int base;
    bit got;
    start_miss(addr, dirty, vtag, vline);
    base = fill_cnt;
    cyc  = 0;
    got  = 1'b0;
    while (!got && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check_val("busy", bus.busy_o, 1'b1);
        check_val("ready_busy", bus.miss_ready_o, 1'b0);
      end
      if (poke) begin
        bus.miss_v_i = (cyc >= 2 && cyc <= 4);
        if (cyc == 2) bus.miss_addr_i = $urandom();
      end
      if (bus.fill_v_o) begin
        got        = 1'b1;
        last_line  = bus.fill_line_o;
        last_tag   = bus.fill_tag_o;
        last_index = bus.fill_index_o;
        check_val("fill_index", bus.fill_index_o, exp_index);
        check_val("fill_tag", bus.fill_tag_o, exp_tag);
        check_val("fill_line", bus.fill_line_o, exp_line);
        if (chk_lat) check_val("latency", cyc, dirty ? 13 : 9);
      end
    end
    bus.miss_v_i = 1'b0;
    if (!got) check_val("fill_timeout", bus.fill_v_o, 1'b1);
    @(negedge clk);
    check_val("fill_drop", bus.fill_v_o, 1'b0);
    check_val("fill_hold", bus.fill_line_o, exp_line);
    @(posedge clk);
    #1;
    check_val("xfer_count", n_xfer, exp_addr.size());
    check_val("fill_pulses", fill_cnt - base, 1);
    txn_active = 1'b0;
  endtask

  task automatic reset_mid();
    int cyc;
    int base;
    rdy_mode = 0;
    rd_lat   = 6;
    spur_en  = 1'b0;
    start_miss($urandom(), 1'b0, 24'h0, 128'h0);
    base = fill_cnt;
    cyc  = 0;
    while (n_xfer != 3 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("rst_reach", n_xfer, 3);
    #2;
    reset      = 1'b1;
    txn_active = 1'b0;
    #1;
    check_val("rst_ready", bus.miss_ready_o, 1'b1);
    check_val("rst_busy", bus.busy_o, 1'b0);
    check_val("rst_req_v", bus.mem_req_v_o, 1'b0);
    check_val("rst_addr", bus.mem_addr_o, 32'h0);
    check_val("rst_fill_v", bus.fill_v_o, 1'b0);
    check_val("rst_fill_line", bus.fill_line_o, 128'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check_val("rst_no_fill", fill_cnt - base, 0);
    check_val("rst_idle", bus.miss_ready_o, 1'b1);
    rd_lat = 0;
  endtask

  initial begin : main
    logic [31:0] a;
    bus.miss_v_i       = 1'b0;
    bus.miss_addr_i    = '0;
    bus.victim_dirty_i = 1'b0;
    bus.victim_tag_i   = '0;
    bus.victim_line_i  = '0;
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("reset_ready", bus.miss_ready_o, 1'b1);
    check_val("reset_busy", bus.busy_o, 1'b0);
    check_val("reset_req_v", bus.mem_req_v_o, 1'b0);
    check_val("reset_we", bus.mem_we_o, 1'b0);
    check_val("reset_fill_v", bus.fill_v_o, 1'b0);
    check_val("reset_fill_line", bus.fill_line_o, 128'h0);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_reset_ready", bus.miss_ready_o, 1'b1);

    // Clean miss with known memory words.
    mem_aa[32'h0000_1230] = 32'hA0;
    mem_aa[32'h0000_1234] = 32'hA1;
    mem_aa[32'h0000_1238] = 32'hA2;
    mem_aa[32'h0000_123C] = 32'hA3;
    run_miss(32'h0000_1230, 1'b0, 24'h0, 128'h0, 1'b0, 1'b1);
    check_val("tp_clean_line", last_line, 128'h000000A3_000000A2_000000A1_000000A0);
    check_val("tp_clean_tag", last_tag, 24'h000012);
    check_val("tp_clean_index", last_index, 4'h3);

    // Dirty miss: writeback to 0xABCDEF70.. precedes the refill.
    run_miss(32'h0000_5670, 1'b1, 24'hABCDEF, 128'h00000044_00000033_00000022_00000011,
             1'b0, 1'b1);

    // Backpressure on every request.
    rdy_mode = 2;
    run_miss($urandom(), 1'b1, 24'($urandom()), rnd_line(), 1'b0, 1'b0);
    rdy_mode = 0;

    // Spurious read data while idle and during writeback.
    spur_en = 1'b1;
    repeat (6) @(negedge clk);
    run_miss($urandom(), 1'b1, 24'($urandom()), rnd_line(), 1'b0, 1'b1);
    spur_en = 1'b0;

    // New miss requests while busy are ignored.
    run_miss($urandom(), 1'b1, 24'($urandom()), rnd_line(), 1'b1, 1'b1);

    // Victim tag equal to the miss tag still writes back.
    a = $urandom();
    run_miss(a, 1'b1, a[31:8], rnd_line(), 1'b0, 1'b1);

    // Reset in the middle of the third read, then a normal miss.
    reset_mid();
    run_miss($urandom(), 1'b0, 24'h0, rnd_line(), 1'b0, 1'b1);

    for (int i = 0; i < 25; i++) begin
      logic [31:0] ra;
      logic [23:0] vt;
      bit          d;
      ra       = $urandom();
      d        = 1'($urandom_range(0, 1));
      vt       = ($urandom_range(0, 3) == 0) ? ra[31:8] : 24'($urandom());
      rdy_mode = $urandom_range(0, 1);
      rd_lat   = $urandom_range(0, 2);
      spur_en  = 1'($urandom_range(0, 1));
      run_miss(ra, d, vt, rnd_line(), 1'($urandom_range(0, 1)), (rdy_mode == 0 && rd_lat == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Memory-side miss handler for the 4-way, 16-set, 16B-line cache (24b tag / 4b index / 4b offset).
- Accepts one miss from the cache lookup, writes back the dirty victim line word-by-word, then burst-reads the missing line from memory one word at a time.
- Returns the assembled 128-bit line plus its index and tag to the cache as a single-cycle fill strobe.

Parameters:
- ADDR_W, 32, byte address width
- INDEX_W, 4, set index bits
- WORDS, 4, 32-bit words per line (offset = 4 bits, word select = address[3:2])
- TAG_W, 24, tag bits; fixed as ADDR_W-INDEX_W-4

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous reset, active-high
- miss_v_i  in  1  miss request valid
- miss_ready_o  out  1  controller idle, can accept a miss
- miss_addr_i  in  32  missing byte address
- victim_dirty_i  in  1  chosen victim way is valid and dirty
- victim_tag_i  in  24  victim tag
- victim_line_i  in  128  victim data; word k = bits [32k+31:32k]
- mem_req_v_o  out  1  memory request valid
- mem_req_ready_i  in  1  memory accepts request this cycle
- mem_we_o  out  1  1=write, 0=read
- mem_addr_o  out  32  word-aligned address
- mem_wdata_o  out  32  write data
- mem_rdata_v_i  in  1  read data valid
- mem_rdata_i  in  32  read data
- fill_v_o  out  1  one-cycle fill strobe to the cache (drives cache wen)
- fill_index_o  out  4  set to fill
- fill_tag_o  out  24  tag to install
- fill_line_o  out  128  refilled line
- busy_o  out  1  not IDLE

Behaviour:
- Reset (async, reset_i=1) forces state IDLE and clears word counter k, line buffer, and latched address/victim.
  - All outputs are 0 during and after reset, except miss_ready_o=1.
- Handshakes:
  - Miss accepted when miss_v_i & miss_ready_o on a rising edge.
  - Acceptance latches miss_addr_i[31:4], victim_dirty_i, victim_tag_i and victim_line_i.
  - Later changes on these inputs are ignored.
  - miss_ready_o = (state==IDLE); miss_v_i is ignored in every other state.
  - A memory request transfers when mem_req_v_o & mem_req_ready_i.
  - mem_addr_o, mem_we_o and mem_wdata_o stay stable while mem_req_v_o=1 and ready=0.
- States:
  - IDLE: on accept, k=0, then go to WB_REQ if victim_dirty_i=1, else RD_REQ.
  - WB_REQ:
    - Drives mem_req_v_o=1, mem_we_o=1, mem_addr_o={victim_tag, index, k[1:0], 2'b00}, mem_wdata_o=victim word k.
    - On transfer: if k==3, set k=0 and go to RD_REQ; else k++.
  - RD_REQ:
    - Drives mem_req_v_o=1, mem_we_o=0, mem_addr_o={tag, index, k[1:0], 2'b00}.
    - On transfer, go to RD_DATA.
  - RD_DATA:
    - mem_req_v_o=0. On mem_rdata_v_i, capture mem_rdata_i into line word k.
    - If k==3, go to FILL; else k++ and go to RD_REQ.
    - Waits indefinitely for data.
  - FILL:
    - fill_v_o=1 for exactly one cycle, with fill_index_o/fill_tag_o from the latched miss and fill_line_o = assembled buffer.
    - Then go to IDLE. No back-to-back accept in the FILL cycle.
- Outputs:
  - fill_* values are held stable outside FILL (last value); only fill_v_o qualifies them.
  - mem_wdata_o = 0 when mem_we_o=0.
  - busy_o = !miss_ready_o.
- Latency, with mem_req_ready_i held 1 and rdata returned the cycle after the read request:
  - Clean miss: fill_v_o asserts 9 cycles after the accept edge.
  - Dirty miss: +4 cycles (13).
- Boundary conditions:
  - mem_rdata_v_i outside RD_DATA is ignored and never corrupts the buffer.
  - Word order is always 0..3; counter k is 2 bits, with terminal value 3 checked explicitly (no wrap reuse).
  - Victim tag equal to miss tag still performs the writeback.
  - Reset mid-operation (any state) abandons the transaction with no fill; late rdata after reset is ignored.

Test Plan:
- Clean miss, addr=0x0000_1230, ready=1, rdata 1-cycle latency with words 0xA0,0xA1,0xA2,0xA3 -> read addrs 0x1230,0x1234,0x1238,0x123C, no writes, fill_v_o at cycle 9 with index=3, tag=0x000012, line=0x000000A3_000000A2_000000A1_000000A0.
- Dirty miss, addr=0x0000_5670, victim_tag=0xABCDEF, victim_line words 0x11..0x44 -> writes first to 0xABCDEF70..0xABCDEF7C with data 0x11,0x22,0x33,0x44, then reads from 0x5670..0x567C, fill at cycle 13.
- Backpressure: ready low 3 cycles on each request -> addr/we/wdata stable while stalled, no duplicate transfers, correct line.
- Spurious mem_rdata_v_i=1 (0xDEAD) during WB_REQ and IDLE -> not captured into line.
- miss_v_i pulsed while busy, with changed miss_addr_i -> ignored, fill uses the original tag/index, single fill_v_o pulse.
- reset_i asserted during RD_DATA of word 2 -> outputs 0 immediately, miss_ready_o=1; next miss completes normally.
